cos_sweep_ctrl: RTL and testbench

- Upstream sequencer for the cosine core (cosinoss).
- Generates a run of angles `x_base + k*x_step` for k = 0..count-1 and drives the core's start/x/y inputs.
- Waits for `done` on each angle, then captures `{intpart, fracpart}` into a small result FIFO.
- Downstream logic drains the FIFO with a valid/ready handshake.

---
 rtl/cos_sweep_pkg.sv | 20 ++
 rtl/cos_res_fifo.sv | 57 +++++
 rtl/cos_sweep_ctrl.sv | 168 ++++++++++++++++
 tb/tb_cos_sweep_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cos_sweep_pkg.sv
// Shared types for the cosine-core sweep sequencer: FSM states and the
// captured result layout.
package cos_sweep_pkg;

    localparam int XW = 10;
    localparam int RW = 10;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        STORE
    } state_t;

    typedef struct packed {
        logic [1:0] ip;
        logic [7:0] fp;
    } result_t;

endpackage

// File: rtl/cos_res_fifo.sv
// Synchronous result FIFO: DEPTH entries (power of 2), head presented from
// storage, push accepted while full only when a pop happens on the same edge.
module cos_res_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic         o_full,
    output logic         o_empty,
    output logic [W-1:0] o_data
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_do_push;
    logic          w_do_pop;

    assign o_empty   = (r_cnt == '0);
    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_data    = r_mem[r_rd];

    // Storage, pointers and occupancy; reset flushes everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_do_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/cos_sweep_ctrl.sv
// Sweep sequencer for the cosine core: issues x_base + k*x_step for
// k = 0..count-1, waits for done, captures {int, frac} into a result FIFO.
// Optional watchdog in WAIT enabled by defining COS_SWEEP_TIMEOUT_EN.
module cos_sweep_ctrl #(
    parameter int XW          = 10,
    parameter int YW          = 8,
    parameter int RW          = 10,
    parameter int CNTW        = 8,
    parameter int DEPTH       = 4,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            go,
    input  logic [XW-1:0]   x_base,
    input  logic [XW-1:0]   x_step,
    input  logic [CNTW-1:0] count,
    input  logic [YW-1:0]   y_cfg,
    output logic            busy,
    output logic            cos_start,
    output logic [XW-1:0]   cos_x,
    output logic [YW-1:0]   cos_y,
    input  logic            cos_done,
    input  logic [1:0]      cos_int,
    input  logic [7:0]      cos_frac,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [RW-1:0]   res_data,
    output logic            err
);

    import cos_sweep_pkg::*;

    state_t          r_state;
    state_t          w_next;
    logic [XW-1:0]   r_x;
    logic [XW-1:0]   r_step;
    logic [CNTW-1:0] r_rem;
    logic [YW-1:0]   r_y;
    logic            r_armed;
    logic            w_load;
    logic            w_adv;
    logic            w_push;
    logic            w_full;
    logic            w_empty;
    logic            w_timeout;
    result_t         w_res;

    assign w_res     = {cos_int, cos_frac};
    assign busy      = (r_state != IDLE);
    assign cos_start = (r_state == ISSUE);
    assign cos_x     = r_x;
    assign cos_y     = r_y;
    assign res_valid = !w_empty;

`ifdef COS_SWEEP_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYC + 1);

    logic [TOW-1:0] r_to_cnt;
    logic           r_err;

    // Abort on the TIMEOUT_CYC-th WAIT cycle unless an accepted done arrives then.
    assign w_timeout = (r_state == WAIT) && !(cos_done && r_armed) &&
                       (r_to_cnt == TOW'(TIMEOUT_CYC - 1));
    assign err = r_err;

    // Watchdog counter runs only in WAIT; err is sticky until reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt <= '0;
            r_err    <= 1'b0;
        end else begin
            r_to_cnt <= (r_state == WAIT) ? r_to_cnt + TOW'(1) : '0;
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_timeout = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state and control strobes.
    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_adv  = 1'b0;
        w_push = 1'b0;
        case (r_state)
            IDLE: begin
                if (go && (count != '0)) begin
                    w_load = 1'b1;
                    w_next = ISSUE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (w_timeout) begin
                    w_next = IDLE;
                end else if (cos_done && r_armed) begin
                    w_next = STORE;
                end
            end
            STORE: begin
                if (!w_full) begin
                    w_push = 1'b1;
                    if (r_rem == CNTW'(1)) begin
                        w_next = IDLE;
                    end else begin
                        w_adv  = 1'b1;
                        w_next = ISSUE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Sweep datapath: latched config, current angle, remaining count.
    // r_armed masks a done that is still high on the first WAIT cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x     <= '0;
            r_step  <= '0;
            r_rem   <= '0;
            r_y     <= '0;
            r_armed <= 1'b0;
        end else begin
            r_armed <= (r_state == WAIT);
            if (w_load) begin
                r_x    <= x_base;
                r_step <= x_step;
                r_rem  <= count;
                r_y    <= y_cfg;
            end else if (w_adv) begin
                r_x <= r_x + r_step;
            end
            if (w_push) begin
                r_rem <= r_rem - CNTW'(1);
            end
        end
    end

    cos_res_fifo #(
        .W     (RW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (w_res),
        .i_pop   (res_ready),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_data  (res_data)
    );

endmodule

// File: tb/tb_cos_sweep_ctrl.sv
// Directed bench for cos_sweep_ctrl with a stub cosine core.
// Stub result for angle x: int = x[9:8] ^ 2'b01, frac = x[7:0] ^ 8'h35,
// done rises 6 edges after the start pulse and drops on the next start.
module tb_cos_sweep_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       go;
    logic [9:0] x_base;
    logic [9:0] x_step;
    logic [7:0] count;
    logic [7:0] y_cfg;
    logic       busy;
    logic       cos_start;
    logic [9:0] cos_x;
    logic [7:0] cos_y;
    logic       cos_done;
    logic [1:0] cos_int;
    logic [7:0] cos_frac;
    logic       res_valid;
    logic       res_ready;
    logic [9:0] res_data;
    logic       err;

    int n_checks = 0;
    int n_err    = 0;
    int n_start  = 0;
    logic [9:0] xs[$];
    logic [9:0] got[$];
    logic       stub_mute = 1'b0;
    int         stub_cnt;
    logic [9:0] stub_x;

    always #5 clk = ~clk;

    cos_sweep_ctrl #(
        .XW          (10),
        .YW          (8),
        .RW          (10),
        .CNTW        (8),
        .DEPTH       (4),
        .TIMEOUT_CYC (255)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .go        (go),
        .x_base    (x_base),
        .x_step    (x_step),
        .count     (count),
        .y_cfg     (y_cfg),
        .busy      (busy),
        .cos_start (cos_start),
        .cos_x     (cos_x),
        .cos_y     (cos_y),
        .cos_done  (cos_done),
        .cos_int   (cos_int),
        .cos_frac  (cos_frac),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .err       (err)
    );

    // Stub core: level done after a fixed delay, outputs held until next start.
    always @(posedge clk) begin
        if (rst) begin
            cos_done <= 1'b0;
            cos_int  <= 2'b00;
            cos_frac <= 8'h00;
            stub_cnt <= 0;
        end else if (cos_start) begin
            cos_done <= 1'b0;
            stub_x   <= cos_x;
            stub_cnt <= 5;
        end else if (stub_cnt != 0) begin
            stub_cnt <= stub_cnt - 1;
            if (stub_cnt == 1 && !stub_mute) begin
                cos_done <= 1'b1;
                cos_int  <= stub_x[9:8] ^ 2'b01;
                cos_frac <= stub_x[7:0] ^ 8'h35;
            end
        end
    end

    // Monitor: record issued angles and accepted results.
    always @(negedge clk) begin
        if (cos_start) begin
            n_start = n_start + 1;
            xs.push_back(cos_x);
        end
        if (res_valid && res_ready) begin
            got.push_back(res_data);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        n_start = 0;
        xs.delete();
        got.delete();
    endtask

    task automatic pulse_go(input logic [9:0] b, input logic [9:0] s,
                            input logic [7:0] c, input logic [7:0] y);
        go = 1'b1; x_base = b; x_step = s; count = c; y_cfg = y;
        tick();
        go = 1'b0; x_base = 10'h2AA; x_step = 10'h155; count = 8'hEE; y_cfg = 8'h00;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (busy && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drained(input string tag, input int budget);
        int n = 0;
        while (res_valid && n < budget) begin
            tick();
            n++;
        end
        check(tag, {31'd0, res_valid}, 32'd0);
    endtask

    logic [9:0] exp_x[$];
    logic [9:0] exp_r[$];

    task automatic check_lists(input string tag);
        check({tag, "_nstart"}, n_start, exp_x.size());
        check({tag, "_nres"}, got.size(), exp_r.size());
        foreach (exp_x[i]) begin
            check($sformatf("%s_x%0d", tag, i), (i < xs.size()) ? xs[i] : 10'h3FF ^ exp_x[i], exp_x[i]);
        end
        foreach (exp_r[i]) begin
            check($sformatf("%s_r%0d", tag, i), (i < got.size()) ? got[i] : 10'h3FF ^ exp_r[i], exp_r[i]);
        end
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; x_base = '0; x_step = '0; count = '0; y_cfg = '0;
        res_ready = 1'b0;
        tick(); tick();
        check("rst_busy", busy, 0);
        check("rst_start", cos_start, 0);
        check("rst_valid", res_valid, 0);
        check("rst_x", cos_x, 0);
        check("rst_y", cos_y, 0);
        check("rst_data", res_data, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        tick();

        // count == 0 is a no-op
        clear_mon();
        pulse_go(10'h123, 10'h001, 8'd0, 8'h77);
        check("cnt0_busy", busy, 0);
        tick(); tick();
        check("cnt0_nstart", n_start, 0);

        // single angle
        clear_mon();
        pulse_go(10'h180, 10'h000, 8'd1, 8'h5C);
        check("single_busy", busy, 1);
        check("single_start", cos_start, 1);
        check("single_x", cos_x, 10'h180);
        check("single_y", cos_y, 8'h5C);
        wait_idle("single_idle", 100);
        check("single_nstart", n_start, 1);
        check("single_valid", res_valid, 1);
        check("single_data", res_data, 10'h0B5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("single_empty", res_valid, 0);

        // sweep of 4 with consumer always ready; a go mid-sweep is ignored
        clear_mon();
        res_ready = 1'b1;
        pulse_go(10'h000, 10'h040, 8'd4, 8'h11);
        tick(); tick(); tick();
        pulse_go(10'h3FF, 10'h001, 8'd1, 8'h22);
        check("sweep_y", cos_y, 8'h11);
        wait_idle("sweep_idle", 300);
        wait_drained("sweep_drain", 20);
        exp_x = '{10'h000, 10'h040, 10'h080, 10'h0C0};
        exp_r = '{10'h135, 10'h175, 10'h1B5, 10'h1F5};
        check_lists("sweep");

        // angle wrap
        clear_mon();
        pulse_go(10'h3F0, 10'h020, 8'd2, 8'h33);
        wait_idle("wrap_idle", 200);
        wait_drained("wrap_drain", 20);
        exp_x = '{10'h3F0, 10'h010};
        exp_r = '{10'h2C5, 10'h125};
        check_lists("wrap");

        // backpressure: FIFO fills, FSM stalls in STORE holding the 5th result
        clear_mon();
        res_ready = 1'b0;
        pulse_go(10'h100, 10'h010, 8'd6, 8'h44);
        repeat (150) tick();
        check("bp_nstart", n_start, 5);
        check("bp_busy", busy, 1);
        check("bp_valid", res_valid, 1);
        check("bp_head", res_data, 10'h035);
        repeat (20) tick();
        check("bp_nstart_hold", n_start, 5);
        res_ready = 1'b1;
        wait_idle("bp_idle", 300);
        wait_drained("bp_drain", 20);
        exp_x = '{10'h100, 10'h110, 10'h120, 10'h130, 10'h140, 10'h150};
        exp_r = '{10'h035, 10'h025, 10'h015, 10'h005, 10'h075, 10'h065};
        check_lists("bp");

        // reset during WAIT of the 2nd angle
        clear_mon();
        res_ready = 1'b0;
        pulse_go(10'h000, 10'h040, 8'd4, 8'h55);
        begin
            int n = 0;
            while (n_start < 2 && n < 100) begin
                tick();
                n++;
            end
        end
        check("mid_reach2", n_start, 2);
        tick(); tick();
        check("mid_prevalid", res_valid, 1);
        rst = 1'b1;
        tick();
        check("mid_busy", busy, 0);
        check("mid_valid", res_valid, 0);
        check("mid_start", cos_start, 0);
        rst = 1'b0;
        tick();
        clear_mon();
        pulse_go(10'h180, 10'h000, 8'd1, 8'h66);
        wait_idle("post_idle", 100);
        check("post_nstart", n_start, 1);
        check("post_data", res_data, 10'h0B5);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("post_empty", res_valid, 0);

`ifdef COS_SWEEP_TIMEOUT_EN
        // watchdog: done never arrives
        stub_mute = 1'b1;
        pulse_go(10'h200, 10'h000, 8'd1, 8'h00);
        tick();
        repeat (254) tick();
        check("to_err_early", err, 0);
        check("to_busy_early", busy, 1);
        tick();
        check("to_err", err, 1);
        check("to_busy", busy, 0);
        repeat (10) tick();
        check("to_err_sticky", err, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("to_err_clr", err, 0);
        stub_mute = 1'b0;
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
